// File: rtl/prog_mem_sync.sv
// Program/data memory with a dual-word fetch port, a data read port and a write port.
// Latency: a request accepted in cycle N returns data and its valid/ack/err pulse in cycle N+1.
// Backpressure: none; while ready is low every request is dropped, and once ready is high every port accepts each cycle.
module prog_mem_sync #(
  parameter int                DATA_W         = 8,
  parameter int                ADDR_W         = 8,
  parameter int                DEPTH          = 256,
  parameter logic [DATA_W-1:0] FILL           = '0,
  parameter bit                CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              fetchEn,
  input  logic [ADDR_W-1:0] fetchAddr,
  output logic [DATA_W-1:0] fetchData0,
  output logic [DATA_W-1:0] fetchData1,
  output logic              fetchValid,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] rdAddr,
  output logic [DATA_W-1:0] rdData,
  output logic              rdValid,
  input  logic              wrEn,
  input  logic [ADDR_W-1:0] wrAddr,
  input  logic [DATA_W-1:0] wrData,
  output logic              wrAck,
  output logic              errAddr
);

  // DEPTH may equal 2**ADDR_W, so range compares are done one bit wider.
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_C  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE_C   = ADDR_W'(1);

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              clr_we;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              ready_w;
  logic              fetch_acc, rd_acc, wr_acc;
  logic              fa0_in, fa1_in, ra_in, wa_in;
  logic [ADDR_W-1:0] fetch_addr1;
  logic              wr_hit;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] fetch_data0_q, fetch_data0_d;
  logic [DATA_W-1:0] fetch_data1_q, fetch_data1_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wr_ack_q, wr_ack_d;
  logic              err_addr_q, err_addr_d;

  // Clear sequencer: sweep FILL across every word, then sit in READY until reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    if (state_q == CLEAR) begin
      clr_we = 1'b1;
      cnt_d  = cnt_q + ONE_C;
      if (cnt_q == LAST_C) begin
        state_d = READY;
        cnt_d   = '0;
      end
    end
  end

  // FSM state and sweep counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR_ON_RESET ? CLEAR : READY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request qualification, range checks and array write selection.
  always_comb begin
    ready_w   = (state_q == READY);
    fetch_acc = ready_w & fetchEn;
    rd_acc    = ready_w & rdEn;
    wr_acc    = ready_w & wrEn;

    fa0_in = ({1'b0, fetchAddr} < DEPTH_C);
    ra_in  = ({1'b0, rdAddr} < DEPTH_C);
    wa_in  = ({1'b0, wrAddr} < DEPTH_C);

    // Second fetch word wraps at DEPTH-1 regardless of whether DEPTH is a power of two.
    // An out-of-range A makes both fetch words out of range.
    fetch_addr1 = (fetchAddr == LAST_C) ? '0 : fetchAddr + ONE_C;
    fa1_in      = fa0_in;

    wr_hit = wr_acc & wa_in;

    // The sweep and the write port are never active together (sweep only runs while not ready).
    mem_we    = (clr_we | wr_hit) & ~rst;
    mem_waddr = clr_we ? cnt_q : wrAddr;
    mem_wdata = clr_we ? FILL : wrData;
  end

  // Array write: no reset, contents survive rst when the sweep is disabled.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Next-state for the registered outputs: hold data, pulse flags, write-first bypass.
  always_comb begin
    fetch_data0_d = fetch_data0_q;
    fetch_data1_d = fetch_data1_q;
    rd_data_d     = rd_data_q;
    fetch_valid_d = fetch_acc;
    rd_valid_d    = rd_acc;
    wr_ack_d      = wr_hit;
    err_addr_d    = (fetch_acc & ~fa0_in) | (rd_acc & ~ra_in) | (wr_acc & ~wa_in);

    if (fetch_acc) begin
      if (!fa0_in) begin
        fetch_data0_d = FILL;
      end else if (wr_hit && (wrAddr == fetchAddr)) begin
        fetch_data0_d = wrData;
      end else begin
        fetch_data0_d = mem[fetchAddr];
      end

      if (!fa1_in) begin
        fetch_data1_d = FILL;
      end else if (wr_hit && (wrAddr == fetch_addr1)) begin
        fetch_data1_d = wrData;
      end else begin
        fetch_data1_d = mem[fetch_addr1];
      end
    end

    if (rd_acc) begin
      if (!ra_in) begin
        rd_data_d = FILL;
      end else if (wr_hit && (wrAddr == rdAddr)) begin
        rd_data_d = wrData;
      end else begin
        rd_data_d = mem[rdAddr];
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_data0_q <= '0;
      fetch_data1_q <= '0;
      rd_data_q     <= '0;
      fetch_valid_q <= 1'b0;
      rd_valid_q    <= 1'b0;
      wr_ack_q      <= 1'b0;
      err_addr_q    <= 1'b0;
    end else begin
      fetch_data0_q <= fetch_data0_d;
      fetch_data1_q <= fetch_data1_d;
      rd_data_q     <= rd_data_d;
      fetch_valid_q <= fetch_valid_d;
      rd_valid_q    <= rd_valid_d;
      wr_ack_q      <= wr_ack_d;
      err_addr_q    <= err_addr_d;
    end
  end

  assign ready      = ready_w;
  assign fetchData0 = fetch_data0_q;
  assign fetchData1 = fetch_data1_q;
  assign rdData     = rd_data_q;
  assign fetchValid = fetch_valid_q;
  assign rdValid    = rd_valid_q;
  assign wrAck      = wr_ack_q;
  assign errAddr    = err_addr_q;

endmodule

// File: tb/tb_prog_mem_sync.sv
// Bench for prog_mem_sync: three instances (default, DEPTH=200, CLEAR_ON_RESET=0) on shared stimulus.
// Inputs change 1 time unit after the rising edge; outputs are sampled at the same point.
// Every comparison goes through check_val.
module tb_prog_mem_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic       fetchEn, rdEn, wrEn;
  logic [7:0] fetchAddr, rdAddr, wrAddr, wrData;

  logic       a_ready, a_fv, a_rv, a_wack, a_err;
  logic [7:0] a_fd0, a_fd1, a_rd;
  logic       b_ready, b_fv, b_rv, b_wack, b_err;
  logic [7:0] b_fd0, b_fd1, b_rd;
  logic       c_ready, c_fv, c_rv, c_wack, c_err;
  logic [7:0] c_fd0, c_fd1, c_rd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  prog_mem_sync u_a (
    .clk(clk), .rst(rst), .ready(a_ready),
    .fetchEn(fetchEn), .fetchAddr(fetchAddr), .fetchData0(a_fd0), .fetchData1(a_fd1), .fetchValid(a_fv),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(a_rd), .rdValid(a_rv),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrAck(a_wack), .errAddr(a_err)
  );

  prog_mem_sync #(.DEPTH(200)) u_b (
    .clk(clk), .rst(rst), .ready(b_ready),
    .fetchEn(fetchEn), .fetchAddr(fetchAddr), .fetchData0(b_fd0), .fetchData1(b_fd1), .fetchValid(b_fv),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(b_rd), .rdValid(b_rv),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrAck(b_wack), .errAddr(b_err)
  );

  prog_mem_sync #(.CLEAR_ON_RESET(1'b0)) u_c (
    .clk(clk), .rst(rst), .ready(c_ready),
    .fetchEn(fetchEn), .fetchAddr(fetchAddr), .fetchData0(c_fd0), .fetchData1(c_fd1), .fetchValid(c_fv),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(c_rd), .rdValid(c_rv),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData), .wrAck(c_wack), .errAddr(c_err)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fetchEn = 1'b0;
    rdEn    = 1'b0;
    wrEn    = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    fetchEn = 1'b0; rdEn = 1'b0; wrEn = 1'b0;
    fetchAddr = '0; rdAddr = '0; wrAddr = '0; wrData = '0;

    // Reset values
    tick();
    tick();
    check_val("rst_ready", a_ready, 0);
    check_val("rst_fv", a_fv, 0);
    check_val("rst_rv", a_rv, 0);
    check_val("rst_wack", a_wack, 0);
    check_val("rst_err", a_err, 0);
    check_val("rst_fd0", a_fd0, 0);
    check_val("rst_fd1", a_fd1, 0);
    check_val("rst_rd", a_rd, 0);

    // Clear sweep length: DEPTH cycles after rst drops
    rst = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      tick();
      if (n == 1)   check_val("nc_ready_first", c_ready, 1);
      if (n == 199) check_val("d200_ready_199", b_ready, 0);
      if (n == 200) check_val("d200_ready_200", b_ready, 1);
      if (n == 255) check_val("ready_255", a_ready, 0);
      if (n == 256) check_val("ready_256", a_ready, 1);
    end

    // Every address reads FILL, back-to-back
    for (int i = 0; i < 256; i++) begin
      rdEn = 1'b1;
      rdAddr = 8'(i);
      tick();
      check_val($sformatf("clr_rd_%0d", i), a_rd, 0);
      check_val($sformatf("clr_rv_%0d", i), a_rv, 1);
    end
    idle();
    tick();
    check_val("rv_pulse_end", a_rv, 0);
    check_val("rd_hold", a_rd, 0);

    // Write then fetch across it
    wrEn = 1'b1; wrAddr = 8'h10; wrData = 8'hAA;
    tick();
    check_val("wack_10", a_wack, 1);
    check_val("err_10", a_err, 0);
    idle();
    fetchEn = 1'b1; fetchAddr = 8'h0F;
    tick();
    check_val("fetch0F_d0", a_fd0, 8'h00);
    check_val("fetch0F_d1", a_fd1, 8'hAA);
    check_val("fetch0F_fv", a_fv, 1);
    check_val("fetch0F_wack_end", a_wack, 0);
    idle();
    tick();
    check_val("fv_pulse_end", a_fv, 0);
    check_val("fd1_hold", a_fd1, 8'hAA);

    // Write-first on read port
    wrEn = 1'b1; wrAddr = 8'h20; wrData = 8'h5C;
    rdEn = 1'b1; rdAddr = 8'h20;
    tick();
    check_val("wf_rd", a_rd, 8'h5C);
    check_val("wf_wack", a_wack, 1);
    idle();
    rdEn = 1'b1; rdAddr = 8'h20;
    tick();
    check_val("rd_20_after", a_rd, 8'h5C);

    // Write-first on fetch word1
    idle();
    wrEn = 1'b1; wrAddr = 8'h30; wrData = 8'h77;
    fetchEn = 1'b1; fetchAddr = 8'h2F;
    tick();
    check_val("wf_fetch_d0", a_fd0, 8'h00);
    check_val("wf_fetch_d1", a_fd1, 8'h77);

    // DEPTH=200 wrap and out-of-range handling
    idle();
    wrEn = 1'b1; wrAddr = 8'h00; wrData = 8'h11;
    tick();
    check_val("d200_wack_0", b_wack, 1);
    idle();
    fetchEn = 1'b1; fetchAddr = 8'd199;
    tick();
    check_val("d200_wrap_d1", b_fd1, 8'h11);
    check_val("d200_wrap_d0", b_fd0, 8'h00);
    check_val("d256_nowrap_d1", a_fd1, 8'h00);
    check_val("d200_wrap_err", b_err, 0);
    idle();
    rdEn = 1'b1; rdAddr = 8'hC8;
    tick();
    check_val("d200_oor_rd", b_rd, 8'h00);
    check_val("d200_oor_rv", b_rv, 1);
    check_val("d200_oor_err", b_err, 1);
    check_val("d256_inr_err", a_err, 0);
    idle();
    wrEn = 1'b1; wrAddr = 8'hC8; wrData = 8'h99;
    tick();
    check_val("d200_oor_wack", b_wack, 0);
    check_val("d200_oorw_err", b_err, 1);
    check_val("d256_c8_wack", a_wack, 1);
    idle();
    fetchEn = 1'b1; fetchAddr = 8'hD0;
    tick();
    check_val("d200_oorf_fv", b_fv, 1);
    check_val("d200_oorf_err", b_err, 1);
    check_val("d200_oorf_d0", b_fd0, 8'h00);
    idle();
    tick();
    check_val("err_pulse_end", b_err, 0);

    // Retention across rst with the sweep disabled; mid-sweep restart for the others
    wrEn = 1'b1; wrAddr = 8'h05; wrData = 8'h33;
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    begin
      int n;
      n = 0;
      tick(); n++;
      check_val("nc_ready_after_rst", c_ready, 1);
      check_val("sweep_ready_after_rst", a_ready, 0);
      rdEn = 1'b1; rdAddr = 8'h05;
      wrEn = 1'b1; wrAddr = 8'h40; wrData = 8'h44;
      fetchEn = 1'b1; fetchAddr = 8'h04;
      tick(); n++;
      check_val("nc_retain_rd", c_rd, 8'h33);
      check_val("nc_retain_rv", c_rv, 1);
      check_val("nc_wack", c_wack, 1);
      check_val("notready_rv", a_rv, 0);
      check_val("notready_fv", a_fv, 0);
      check_val("notready_wack", a_wack, 0);
      idle();
      wrEn = 1'b1; wrAddr = 8'hFF; wrData = 8'h01;
      fetchEn = 1'b1; fetchAddr = 8'hFF;
      tick(); n++;
      check_val("notready_err", b_err, 0);
      check_val("notready_wack2", b_wack, 0);
      idle();
      while (n < 100) begin
        tick(); n++;
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    for (int m = 1; m <= 256; m++) begin
      if (m < 250) begin
        rdEn = 1'b1; rdAddr = 8'h10;
        wrEn = 1'b1; wrAddr = 8'h10; wrData = 8'h55;
      end else begin
        idle();
      end
      tick();
      if (m == 10)  check_val("restart_rv", a_rv, 0);
      if (m == 10)  check_val("restart_wack", a_wack, 0);
      if (m == 255) check_val("restart_ready_255", a_ready, 0);
      if (m == 256) check_val("restart_ready_256", a_ready, 1);
    end
    idle();
    rdEn = 1'b1; rdAddr = 8'h10;
    tick();
    check_val("restart_cleared_10", a_rd, 8'h00);
    check_val("restart_rv_ready", a_rv, 1);
    idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
